// File: rtl/sonar_display_pkg.sv
// Shared screen geometry and plotter state encoding for the sonar overlay.
// Constants only; no logic, no latency, no flow control.
package sonar_display_pkg;
   localparam int WIDTH       = 640;
   localparam int HEIGHT      = 480;
   localparam int PIXEL_COUNT = WIDTH * HEIGHT;
   localparam int ADDR_W      = 19;
   localparam int LINE_STRIDE = 640;
   localparam int COORD_W     = 11;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      PLOT
   } state_e;
endpackage

// File: rtl/bit_ram.sv
// 1-bit simple dual-port RAM: synchronous write, registered read-first read (1 cycle).
// No flow control; both ports accept an access every cycle.
module bit_ram #(
   parameter int DEPTH = 307200,
   parameter int AW    = 19
) (
   input  logic          clk,
   input  logic          wr_vld,
   input  logic [AW-1:0] wr_addr,
   input  logic          wr_dat,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_dat
);
   localparam int IW = $clog2(DEPTH);

   logic mem [DEPTH];
   logic rd_dat_q;

   // Read samples the pre-write contents, so a colliding read returns old data.
   always_ff @(posedge clk) begin
      if (wr_vld) begin
         mem[wr_addr[IW-1:0]] <= wr_dat;
      end
      rd_dat_q <= mem[rd_addr[IW-1:0]];
   end

   assign rd_dat = rd_dat_q;
endmodule

// File: rtl/sonar_overlay_fb.sv
// Overlay bitmap: VGA read port (1-cycle latency), plot port stamping DOTxDOT squares, clear sweep.
// plot_ready drops for DOT*DOT cycles per point and for the full clear; reads never stall.
module sonar_overlay_fb #(
   parameter int WIDTH  = sonar_display_pkg::WIDTH,
   parameter int HEIGHT = sonar_display_pkg::HEIGHT,
   parameter int DOT    = 3
) (
   input  logic        CLK100MHZ,
   input  logic        reset,
   input  logic [18:0] pixel_addr,
   output logic        pixel_data,
   input  logic        plot_valid,
   output logic        plot_ready,
   input  logic [9:0]  plot_x,
   input  logic [8:0]  plot_y,
   input  logic        clear_req,
   output logic        busy
);
   import sonar_display_pkg::*;

   localparam int PIX  = WIDTH * HEIGHT;
   localparam int HALF = (DOT - 1) / 2;

   typedef logic signed [COORD_W-1:0] coord_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX - 1);
   localparam logic [ADDR_W-1:0] PIX_ADDR  = ADDR_W'(PIX);
   localparam coord_t OFS_LO = coord_t'(-HALF);
   localparam coord_t OFS_HI = coord_t'(HALF);

   state_e            state_q, state_d;
   logic              clear_pending_q, clear_pending_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   coord_t            cx_q, cx_d, cy_q, cy_d;
   coord_t            dx_q, dx_d, dy_q, dy_d;
   logic              rd_mask_q, rd_mask_d;

   coord_t            px, py;
   logic              in_view;
   logic [ADDR_W-1:0] plot_addr;
   logic              wr_vld, wr_dat;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic              rd_oob, ram_rd_dat;

   // Signed offsets keep a column past either edge from aliasing into the neighbouring row.
   always_comb begin
      px        = cx_q + dx_q;
      py        = cy_q + dy_q;
      in_view   = !px[COORD_W-1] && (px < coord_t'(WIDTH)) &&
                  !py[COORD_W-1] && (py < coord_t'(HEIGHT));
      plot_addr = ADDR_W'(px) + ADDR_W'(WIDTH) * ADDR_W'(py);
   end

   always_comb begin
      state_d         = state_q;
      clear_pending_d = clear_pending_q;
      clr_addr_d      = clr_addr_q;
      cx_d            = cx_q;
      cy_d            = cy_q;
      dx_d            = dx_q;
      dy_d            = dy_q;
      wr_vld          = 1'b0;
      wr_addr         = clr_addr_q;
      wr_dat          = 1'b0;
      plot_ready      = 1'b0;

      case (state_q)
         CLEAR: begin
            wr_vld = 1'b1;
            if (clr_addr_q == LAST_ADDR) begin
               clr_addr_d = '0;
               state_d    = IDLE;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         IDLE: begin
            plot_ready = !clear_req && !clear_pending_q;
            if (clear_req) begin
               state_d = CLEAR;
            end else if (plot_valid && plot_ready) begin
               cx_d    = coord_t'({1'b0, plot_x});
               cy_d    = coord_t'({2'b00, plot_y});
               dx_d    = OFS_LO;
               dy_d    = OFS_LO;
               state_d = PLOT;
            end
         end
         PLOT: begin
            wr_vld  = in_view;
            wr_addr = plot_addr;
            wr_dat  = 1'b1;
            if (clear_req) begin
               clear_pending_d = 1'b1;
            end
            if (dx_q == OFS_HI) begin
               dx_d = OFS_LO;
               if (dy_q == OFS_HI) begin
                  // A request landing on the final offset still counts as pending.
                  state_d         = (clear_pending_q || clear_req) ? CLEAR : IDLE;
                  clear_pending_d = 1'b0;
               end else begin
                  dy_d = dy_q + coord_t'(1);
               end
            end else begin
               dx_d = dx_q + coord_t'(1);
            end
         end
         default: state_d = CLEAR;
      endcase

      if (reset) begin
         wr_vld = 1'b0;
      end

      rd_oob    = (pixel_addr >= PIX_ADDR);
      rd_addr   = rd_oob ? '0 : pixel_addr;
      rd_mask_d = rd_oob || (state_q == CLEAR);
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         state_q         <= CLEAR;
         clear_pending_q <= 1'b0;
         clr_addr_q      <= '0;
         cx_q            <= '0;
         cy_q            <= '0;
         dx_q            <= '0;
         dy_q            <= '0;
         rd_mask_q       <= 1'b1;
      end else begin
         state_q         <= state_d;
         clear_pending_q <= clear_pending_d;
         clr_addr_q      <= clr_addr_d;
         cx_q            <= cx_d;
         cy_q            <= cy_d;
         dx_q            <= dx_d;
         dy_q            <= dy_d;
         rd_mask_q       <= rd_mask_d;
      end
   end

   bit_ram #(
      .DEPTH (PIX),
      .AW    (ADDR_W)
   ) u_ram (
      .clk     (CLK100MHZ),
      .wr_vld  (wr_vld),
      .wr_addr (wr_addr),
      .wr_dat  (wr_dat),
      .rd_addr (rd_addr),
      .rd_dat  (ram_rd_dat)
   );

   assign pixel_data = ram_rd_dat & ~rd_mask_q;
   assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_sonar_overlay_fb.sv
// Bench for sonar_overlay_fb on a reduced 40x30 screen with a pixel-array model of the bitmap.
module tb_sonar_overlay_fb;
   localparam int W    = 40;
   localparam int H    = 30;
   localparam int DOT  = 3;
   localparam int HALF = (DOT - 1) / 2;
   localparam int NDOT = DOT * DOT;
   localparam int PC   = W * H;

   logic        clk = 1'b0;
   logic        reset;
   logic [18:0] pixel_addr;
   logic        pixel_data;
   logic        plot_valid;
   logic        plot_ready;
   logic [9:0]  plot_x;
   logic [8:0]  plot_y;
   logic        clear_req;
   logic        busy;

   always #5 clk = ~clk;

   sonar_overlay_fb #(.WIDTH(W), .HEIGHT(H), .DOT(DOT)) dut (
      .CLK100MHZ  (clk),
      .reset      (reset),
      .pixel_addr (pixel_addr),
      .pixel_data (pixel_data),
      .plot_valid (plot_valid),
      .plot_ready (plot_ready),
      .plot_x     (plot_x),
      .plot_y     (plot_y),
      .clear_req  (clear_req),
      .busy       (busy)
   );

   int checks = 0;
   int errors = 0;
   bit model [PC];

   typedef struct {
      int x;
      int y;
      int lit;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      foreach (model[i]) model[i] = 1'b0;
   endtask

   task automatic model_plot(input int x, input int y);
      for (int dy = -HALF; dy <= HALF; dy++) begin
         for (int dx = -HALF; dx <= HALF; dx++) begin
            if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
               model[(y + dy) * W + (x + dx)] = 1'b1;
         end
      end
   endtask

   task automatic wait_idle(input string name, input int exp);
      int cnt = 0;
      int rdy_hi = 0;
      while (busy && cnt < exp + 100) begin
         if (plot_ready) rdy_hi++;
         step();
         cnt++;
      end
      chk(name, cnt, exp);
      chk({name, "_rdy"}, rdy_hi, 0);
   endtask

   task automatic sweep(input string name, output int ones);
      int bad = 0;
      ones = 0;
      for (int a = 0; a < PC; a++) begin
         pixel_addr = 19'(a);
         step();
         if (pixel_data !== model[a]) bad++;
         ones += int'(pixel_data);
      end
      chk(name, bad, 0);
   endtask

   task automatic accept(input int x, input int y, input string name);
      int cnt = 0;
      plot_x     = 10'(x);
      plot_y     = 9'(y);
      plot_valid = 1'b1;
      #1;
      while (!plot_ready && cnt < 50) begin
         step();
         cnt++;
      end
      chk({name, "_acc"}, int'(plot_ready), 1);
      step();
      plot_valid = 1'b0;
      model_plot(x, y);
   endtask

   task automatic finish_plot(input string name, input int exp);
      int cnt = 0;
      while (!plot_ready && cnt < 100) begin
         step();
         cnt++;
      end
      chk({name, "_len"}, cnt, exp);
   endtask

   task automatic do_clear(input string name);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      model_clear();
      wait_idle(name, PC);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ones;
      reset      = 1'b1;
      pixel_addr = '0;
      plot_valid = 1'b0;
      plot_x     = '0;
      plot_y     = '0;
      clear_req  = 1'b0;

      tbl[0] = '{10, 5, 9};
      tbl[1] = '{0, 0, 4};
      tbl[2] = '{39, 29, 4};
      tbl[3] = '{39, 0, 4};
      tbl[4] = '{0, 15, 6};
      tbl[5] = '{20, 29, 6};
      tbl[6] = '{40, 5, 3};
      tbl[7] = '{500, 10, 0};
      tbl[8] = '{1023, 511, 0};
      tbl[9] = '{5, 30, 3};

      repeat (3) step();
      chk("rst_busy", int'(busy), 1);
      chk("rst_ready", int'(plot_ready), 0);
      chk("rst_data", int'(pixel_data), 0);

      reset = 1'b0;
      model_clear();
      wait_idle("init_clear", PC);
      sweep("init_zero", ones);

      for (int i = 0; i < 10; i++) begin
         do_clear($sformatf("tbl%0d_clear", i));
         accept(tbl[i].x, tbl[i].y, $sformatf("tbl%0d", i));
         finish_plot($sformatf("tbl%0d", i), NDOT);
         sweep($sformatf("tbl%0d_map", i), ones);
         chk($sformatf("tbl%0d_lit", i), ones, tbl[i].lit);
      end

      // Centre pixel is the 5th offset: same-edge read sees old data, next read sees it set.
      pixel_addr = 19'(10 + W * 10);
      accept(10, 10, "rf");
      repeat (4) step();
      step();
      chk("rf_same", int'(pixel_data), 0);
      step();
      chk("rf_next", int'(pixel_data), 1);
      finish_plot("rf", NDOT - 6);

      accept(0, 0, "corner");
      finish_plot("corner", NDOT);
      pixel_addr = 19'(PC);
      step();
      chk("oob_pc", int'(pixel_data), 0);
      pixel_addr = 19'h7FFFF;
      step();
      chk("oob_max", int'(pixel_data), 0);
      pixel_addr = 19'(W - 1);
      step();
      chk("row0_end", int'(pixel_data), 0);
      pixel_addr = 19'(W);
      step();
      chk("row1_start", int'(pixel_data), 1);
      sweep("corner_map", ones);

      plot_x     = 10'd20;
      plot_y     = 9'd20;
      plot_valid = 1'b1;
      clear_req  = 1'b1;
      #1;
      chk("crpv_ready", int'(plot_ready), 0);
      step();
      clear_req  = 1'b0;
      plot_valid = 1'b0;
      chk("crpv_busy", int'(busy), 1);
      pixel_addr = 19'(10 + W * 10);
      step();
      chk("crpv_clr_read", int'(pixel_data), 0);
      model_clear();
      wait_idle("crpv_clear", PC - 1);
      sweep("crpv_map", ones);

      accept(15, 15, "mid");
      repeat (2) step();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      model_clear();
      wait_idle("mid_clear", (NDOT - 3) + PC);
      sweep("mid_map", ones);

      pixel_addr = 19'(24 + W * 11);
      accept(25, 12, "rstp");
      repeat (3) step();
      chk("rstp_partial", int'(pixel_data), 1);
      reset = 1'b1;
      step();
      chk("rstp_busy", int'(busy), 1);
      chk("rstp_ready", int'(plot_ready), 0);
      chk("rstp_data", int'(pixel_data), 0);
      reset = 1'b0;
      model_clear();
      wait_idle("rstp_clear", PC);
      sweep("rstp_map", ones);

      for (int i = 0; i < 25; i++) begin
         int x;
         int y;
         if ($urandom_range(0, 5) == 0) begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 511);
         end else begin
            x = $urandom_range(0, W + 1);
            y = $urandom_range(0, H + 1);
         end
         repeat ($urandom_range(0, 3)) step();
         accept(x, y, $sformatf("rnd%0d", i));
         finish_plot($sformatf("rnd%0d", i), NDOT);
      end
      sweep("rnd_map", ones);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sonar_overlay_fb.md
# sonar_overlay_fb

1-bit overlay framebuffer sitting directly upstream of the VGA controller: it answers the controller's `pixel_addr` with `pixel_data`, and a high bit forces the displayed pixel green. A plot port accepts sonar echo points as screen coordinates through a valid/ready handshake and stamps a DOT×DOT square into the bitmap. A clear sequencer wipes the bitmap after reset and on request.

## Interface
- `WIDTH`, 640, visible columns
- `HEIGHT`, 480, visible rows
- `DOT`, 3, side of the plotted square in pixels; odd, at least 1
- `CLK100MHZ`  in  1  system clock; every register in the block is on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `pixel_addr`  in  19  read address from the VGA controller, x + 640*y
- `pixel_data`  out  1  overlay bit for `pixel_addr`, registered
- `plot_valid`  in  1  `plot_x`/`plot_y` hold a point to draw
- `plot_ready`  out  1  block accepts a point this cycle
- `plot_x`  in  10  centre column
- `plot_y`  in  9  centre row
- `clear_req`  in  1  one-cycle pulse that requests a full bitmap clear
- `busy`  out  1  high in CLEAR or PLOT

## Operation
- Storage holds WIDTH*HEIGHT bits, one per pixel. Storage contents are not reset; CLEAR initialises them.
- FSM states:
  - CLEAR: writes 0 to one address per cycle, ascending from 0 to PIXEL_COUNT-1, then goes to IDLE.
  - IDLE: `plot_ready` = !`clear_req` && !clear_pending.
  - PLOT: runs DOT*DOT cycles, then goes to CLEAR if clear_pending is set, otherwise to IDLE.
- Reset forces the state to CLEAR, so every reset is followed by a full wipe.
- Accept: `plot_valid && plot_ready` at an edge. The block captures x,y and enters PLOT.
- PLOT writes 1 to offsets (dx,dy), each in -(DOT-1)/2..+(DOT-1)/2. Order is row-major: dy outer, dx inner, one offset per cycle.
- Clipping: an offset with x+dx or y+dy outside 0..WIDTH-1 or 0..HEIGHT-1 suppresses its write but still uses its cycle. Coordinate arithmetic is signed and 11 bits wide, so no wrap into an adjacent row.
- Points whose centre lies fully off-screen are accepted, produce no writes, and take DOT*DOT cycles.
- `clear_req` handling:
  - In IDLE it enters CLEAR on the next edge and wins over a simultaneous `plot_valid`; that point is not accepted.
  - In PLOT it sets clear_pending, which is consumed when PLOT ends.
  - In CLEAR it is ignored and does not restart the sweep.
- Read path: `pixel_data` <= mem[`pixel_addr`] every cycle.
  - Returns 0 if `pixel_addr` >= PIXEL_COUNT.
  - Returns 0 while in CLEAR.
  - Same-cycle read and write to one address returns the old value (read-first).
- Reset mid-PLOT or mid-CLEAR abandons the operation. Pixels already written stay written until the new CLEAR reaches them.

## Timing
- Reset values: `pixel_data`=0, `plot_ready`=0, `busy`=1, state=CLEAR, clear_pending=0.
- First clear write occurs at the first edge with `reset` low.
- CLEAR lasts PIXEL_COUNT = 307200 cycles; `busy` falls in the cycle after the last write.
- Plot accepted at edge N: writes land at edges N+1 … N+DOT*DOT. `plot_ready` is high again in the cycle after edge N+DOT*DOT, which is edge N+9 for DOT=3. Maximum throughput is one point per DOT*DOT+1 cycles.
- Read latency: 1 CLK100MHZ cycle. This is well inside one 25 MHz pixel period.
- A written pixel is visible on the read port 1 cycle after its write edge.

## Structure
- Package `sonar_display_pkg`: WIDTH, HEIGHT, PIXEL_COUNT, ADDR_W=19, `pixel_addr` formula constant 640, FSM state enum {CLEAR, IDLE, PLOT}.
- Sub-module `bit_ram`: simple dual-port RAM, depth PIXEL_COUNT, 1-bit data, synchronous write port, synchronous read-first read port.
- FSM, dot counters and clip logic live in the top.

## Test plan
- Reset pulse with memory preloaded to 1s: `busy`=1 for exactly 307200 cycles, `plot_ready`=0 throughout, then every address reads 0.
- Plot (100,50) with DOT=3: `plot_ready` is low for 9 cycles. Addresses 640*49+99 … 640*51+101 (9 pixels) read 1 and their neighbours read 0.
- Plot (0,0): only 4 writes occur (0, 1, 640, 641). Address 639, the last pixel of row 0, stays 0. PLOT still takes 9 cycles.
- `clear_req` pulsed in the same cycle as `plot_valid` in IDLE: the point is not accepted and CLEAR starts on the next edge. Separately, `clear_req` pulsed mid-PLOT: the dot completes, then CLEAR runs.
- `pixel_addr`=307200 and 524287 read 0. Reading an address in the same cycle it is being plotted returns 0 on that cycle and 1 on the next read.
- `reset` asserted at cycle 4 of a PLOT: `busy` stays 1, a full 307200-cycle CLEAR restarts, and the partial dot is erased.
